empty_addr_dispatch: RTL

Distributes free block addresses from the single shared free-list pop port to the four unpack channels' empty-address inputs (EptyAddr / EptyAddrVld / EptyAddrRcvRdy). A small prefetch buffer per channel lets each unpack engine take a new block address every cycle without waiting for arbitration. A round-robin arbiter decides which channel's buffer is refilled on each free-list pop. It sits between the free-list manager and the unpack scatter-gather DMA.

---
 rtl/switch_pkg.sv | 10 +
 rtl/rr_arbiter.sv | 60 ++++++
 rtl/empty_addr_dispatch.sv | 121 ++++++++++++
 3 files changed

// File: rtl/switch_pkg.sv
// Shared switch definitions: channel count, block address width and the
// block-address type used by the unpack, WRR and MMU blocks.
package switch_pkg;

   localparam int NUM_CH = 4;
   localparam int ADDR_W = 12;

   typedef logic [ADDR_W-1:0] blk_addr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter. It grants the first requester found searching upward
// from the internal pointer. The pointer moves past the winner only when the
// caller strobes iAdvance, so an unused grant does not cost a requester its turn.
module rr_arbiter #(
   parameter int N = 4,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic [N-1:0]     iReq,
   input  logic             iAdvance,
   output logic [N-1:0]     oGrant,
   output logic [IDX_W-1:0] oGrantIdx,
   output logic [IDX_W-1:0] oPtr
);

   logic [IDX_W-1:0] ptr_q, ptr_d;

   // Scan the requesters starting at the pointer and wrapping modulo N.
   // The first hit becomes the grant.
   always_comb begin : searchGrant
      int   sum;
      logic found;
      sum       = 0;
      found     = 1'b0;
      oGrant    = '0;
      oGrantIdx = '0;
      for (int i = 0; i < N; i++) begin
         sum = int'(ptr_q) + i;
         if (sum >= N) begin
            sum = sum - N;
         end
         if (!found && iReq[IDX_W'(sum)]) begin
            found                  = 1'b1;
            oGrant[IDX_W'(sum)]    = 1'b1;
            oGrantIdx              = IDX_W'(sum);
         end
      end
   end

   // After a used grant, the pointer moves to the channel just past the winner.
   always_comb begin
      ptr_d = ptr_q;
      if (iAdvance) begin
         ptr_d = (oGrantIdx == IDX_W'(N - 1)) ? '0 : oGrantIdx + 1'b1;
      end
   end

   // Pointer register. Reset restarts the search at requester 0.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign oPtr = ptr_q;

endmodule

// File: rtl/empty_addr_dispatch.sv
// Hands free block addresses from the single free-list pop port to the
// unpack channels. Each channel keeps a small prefetch FIFO, so its engine can
// take a new address every cycle. A round-robin arbiter decides which
// channel's FIFO is refilled on each free-list pop.
module empty_addr_dispatch
   import switch_pkg::*;
#(
   parameter int PF_DEPTH = 2,
   localparam int LVL_W = $clog2(PF_DEPTH + 1)
) (
   input  logic                     iClk,
   input  logic                     iRst,
   input  logic [ADDR_W-1:0]        iFreeAddr,
   input  logic                     iFreeAddrVld,
   output logic                     oFreeAddrRdy,
   input  logic [NUM_CH-1:0]        iChEn,
   output logic [NUM_CH*ADDR_W-1:0] oEptyAddr,
   output logic [NUM_CH-1:0]        oEptyAddrVld,
   input  logic [NUM_CH-1:0]        iEptyAddrRcvRdy,
   output logic [NUM_CH*LVL_W-1:0]  oChLevel,
   output logic [NUM_CH-1:0]        oStarved
);

   localparam int PTR_W = $clog2(PF_DEPTH);
   localparam int IDX_W = $clog2(NUM_CH);

   logic [NUM_CH-1:0] eligible;
   logic [NUM_CH-1:0] grant;
   logic [IDX_W-1:0]  grantIdx;
   logic [IDX_W-1:0]  rrPtr;
   logic              push;

   // Eligibility uses only registered levels. Ready therefore never depends
   // on iFreeAddrVld or on a consumer pop in the same cycle.
   assign oFreeAddrRdy = |eligible;
   assign push         = iFreeAddrVld & oFreeAddrRdy;

   rr_arbiter #(
      .N(NUM_CH)
   ) uArb (
      .iClk      (iClk),
      .iRst      (iRst),
      .iReq      (eligible),
      .iAdvance  (push),
      .oGrant    (grant),
      .oGrantIdx (grantIdx),
      .oPtr      (rrPtr)
   );

   for (genvar c = 0; c < NUM_CH; c++) begin : gCh
      blk_addr_t          mem_q [PF_DEPTH];
      logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
      logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
      logic [LVL_W-1:0]   level_q, level_d;
      logic               notEmpty;
      logic               chPush;
      logic               chPop;

      assign notEmpty    = (level_q != '0);
      assign chPush      = push & grant[c];
      assign chPop       = notEmpty & iEptyAddrRcvRdy[c];
      assign eligible[c] = iChEn[c] & (level_q < LVL_W'(PF_DEPTH));

      // Pointers wrap naturally. The level only moves when exactly one of
      // push/pop happens, so a simultaneous push and pop keeps it unchanged.
      always_comb begin
         wrPtr_d = wrPtr_q;
         rdPtr_d = rdPtr_q;
         level_d = level_q;
         if (chPush) begin
            wrPtr_d = wrPtr_q + 1'b1;
         end
         if (chPop) begin
            rdPtr_d = rdPtr_q + 1'b1;
         end
         if (chPush && !chPop) begin
            level_d = level_q + 1'b1;
         end else if (!chPush && chPop) begin
            level_d = level_q - 1'b1;
         end
      end

      // Control state resets asynchronously, which discards any buffered
      // addresses; the free-list manager reclaims them.
      always_ff @(posedge iClk or posedge iRst) begin
         if (iRst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
         end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            level_q <= level_d;
         end
      end

      // Entry storage needs no reset: the output mux hides it while the level is 0.
      always_ff @(posedge iClk) begin
         if (chPush) begin
            mem_q[wrPtr_q] <= iFreeAddr;
         end
      end

      assign oEptyAddr[c*ADDR_W +: ADDR_W] = notEmpty ? mem_q[rdPtr_q] : '0;
      assign oEptyAddrVld[c]               = notEmpty;
      assign oChLevel[c*LVL_W +: LVL_W]    = level_q;
      assign oStarved[c]                   = ~notEmpty & ~iFreeAddrVld;
   end

   // Arbiter sanity check. The one-hot and encoded grants must agree, and a
   // requester sitting at the pointer must win.
   always_ff @(posedge iClk) begin
      if (!iRst && (|eligible)) begin
         assert (grant == (NUM_CH'(1) << grantIdx));
         if (eligible[rrPtr]) begin
            assert (grantIdx == rrPtr);
         end
      end
   end

endmodule
